// File: rtl/pipeline_pkg.sv
// Shared fetch/decode pipeline types and constants.
// Holds the instruction width, the NOP encoding, the reset PC and the fetch entry layout.
package pipeline_pkg;

   localparam int          INSTR_W          = 32;
   localparam logic [31:0] NOP_INSTR        = 32'h0;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h00400020;

   typedef struct packed {
      logic [31:0]        pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Small synchronous FIFO with a registered count and a synchronous flush.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; the caller must never push when full or pop when empty.
module if_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 64,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          push_vld,
   input  logic [W-1:0]  push_dat,
   input  logic          pop_vld,
   output logic [W-1:0]  head_dat,
   output logic [CW-1:0] count
);

   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_vld) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop_vld)  rd_ptr <= rd_ptr + PTR_ONE;
         count <= count + CW'(push_vld) - CW'(pop_vld);
      end
   end

   // Storage needs no reset: count gates every read of it.
   always_ff @(posedge clk) begin
      if (push_vld && !flush) mem[wr_ptr] <= push_dat;
   end

   assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue feeding ID: one-cycle imem reads buffered with their PCs.
// Latency: req in cycle N, word pushed end of N+1, valid at ID in N+2 (no bypass).
// Backpressure: id_stall holds the head; reqs stop once queued + in-flight words reach DEPTH.
module if_prefetch_queue
   import pipeline_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic                     imem_req,
   output logic [31:0]              imem_addr,
   input  logic [31:0]              imem_rdata,
   input  logic                     redirect,
   input  logic [31:0]              redirect_pc,
   input  logic                     id_stall,
   output logic [31:0]              instr_id,
   output logic [31:0]              pc_id,
   output logic                     valid_id,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [31:0]   fetch_pc;
   logic [31:0]   fetch_addr_q;
   logic          inflight;
   logic [CW-1:0] count;
   logic [CW:0]   credit;
   logic          pop;
   logic          push;
   fetch_entry_t  head;
   fetch_entry_t  push_entry;

   assign credit    = {1'b0, count} + (CW+1)'(inflight);
   assign pop       = valid_id & ~id_stall & ~redirect;
   assign push      = inflight & ~redirect;
   assign imem_addr = fetch_pc & 32'hFFFF_FFFC;
   assign imem_req  = ~reset & ~redirect & ((credit < (CW+1)'(DEPTH)) | pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc     <= RESET_PC;
         fetch_addr_q <= '0;
         inflight     <= 1'b0;
      end else if (redirect) begin
         // The in-flight word belongs to the old stream and is dropped.
         fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
         inflight <= 1'b0;
      end else begin
         inflight <= imem_req;
         if (imem_req) begin
            fetch_pc     <= imem_addr + 32'd4;
            fetch_addr_q <= imem_addr;
         end
      end
   end

   assign push_entry.pc    = fetch_addr_q;
   assign push_entry.instr = imem_rdata;

   if_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(fetch_entry_t))
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .flush    (redirect),
      .push_vld (push),
      .push_dat (push_entry),
      .pop_vld  (pop),
      .head_dat (head),
      .count    (count)
   );

   assign valid_id  = (count != '0);
   assign occupancy = count;
   assign instr_id  = valid_id ? head.instr : NOP_INSTR;
   assign pc_id     = valid_id ? head.pc    : 32'h0;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Self-checking bench for if_prefetch_queue: scoreboard of fetched PCs plus scenario tasks.
module tb_if_prefetch_queue;
   import pipeline_pkg::*;

   localparam int          DEPTH  = 4;
   localparam logic [31:0] RST_PC = 32'h00400020;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        id_stall;
   logic [31:0] instr_id;
   logic [31:0] pc_id;
   logic        valid_id;
   logic [2:0]  occupancy;

   int checks = 0;
   int errors = 0;
   int pop_cnt = 0;

   logic [63:0] exp_q[$];
   logic [63:0] mon_e;
   logic [31:0] model_pc;
   logic        prev_req;

   if_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .id_stall    (id_stall),
      .instr_id    (instr_id),
      .pc_id       (pc_id),
      .valid_id    (valid_id),
      .occupancy   (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
   endfunction

   // Instruction memory: one-cycle synchronous read.
   always @(posedge clk) begin
      imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;
   end

   // Scoreboard: every req pushes the expected {pc, instr}; every pop compares in order.
   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         model_pc = RST_PC;
         prev_req = 1'b0;
      end else begin
         checks++;
         if (int'(occupancy) + int'(prev_req) > DEPTH) begin
            errors++;
            $display("FAIL credit_overflow occupancy=%0d inflight=%0d limit=%0d", occupancy, prev_req, DEPTH);
         end
         if (redirect) begin
            exp_q.delete();
            model_pc = {redirect_pc[31:2], 2'b00};
         end else if (valid_id && !id_stall) begin
            pop_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL pop_unexpected got pc=%h instr=%h expected no entry", pc_id, instr_id);
            end else begin
               mon_e = exp_q.pop_front();
               if ({pc_id, instr_id} !== mon_e) begin
                  errors++;
                  $display("FAIL pop_order got pc=%h instr=%h expected pc=%h instr=%h",
                           pc_id, instr_id, mon_e[63:32], mon_e[31:0]);
               end
            end
         end
         if (imem_req) begin
            checks++;
            if (imem_addr !== model_pc) begin
               errors++;
               $display("FAIL req_addr got %h expected %h", imem_addr, model_pc);
            end
            exp_q.push_back({model_pc, mem_word(model_pc)});
            model_pc = model_pc + 32'd4;
         end
         prev_req = imem_req;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; redirect = 1'b0; redirect_pc = '0; id_stall = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (valid_id !== 1'b0)   begin errors++; $display("FAIL reset_valid got %b expected 0", valid_id); end
      checks++; if (instr_id !== 32'h0)  begin errors++; $display("FAIL reset_instr got %h expected 0", instr_id); end
      checks++; if (pc_id !== 32'h0)     begin errors++; $display("FAIL reset_pc got %h expected 0", pc_id); end
      checks++; if (imem_req !== 1'b0)   begin errors++; $display("FAIL reset_req got %b expected 0", imem_req); end
      checks++; if (occupancy !== 3'd0)  begin errors++; $display("FAIL reset_occ got %0d expected 0", occupancy); end
   endtask

   task automatic test_startup();
      tick();
      reset = 1'b0;
      @(negedge clk);
      checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
         errors++; $display("FAIL start_req got req=%b addr=%h expected 1 %h", imem_req, imem_addr, RST_PC); end
      @(negedge clk);
      checks++; if (valid_id !== 1'b0) begin errors++; $display("FAIL start_latency1 got valid=%b expected 0", valid_id); end
      @(negedge clk);
      checks++; if (valid_id !== 1'b1 || pc_id !== RST_PC || instr_id !== mem_word(RST_PC)) begin
         errors++; $display("FAIL start_first got valid=%b pc=%h instr=%h expected 1 %h %h",
                            valid_id, pc_id, instr_id, RST_PC, mem_word(RST_PC)); end
      repeat (6) @(negedge clk);
   endtask

   task automatic test_stall();
      tick();
      id_stall = 1'b1;
      repeat (10) @(negedge clk);
      checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL stall_occ got %0d expected 4", occupancy); end
      checks++; if (imem_req !== 1'b0)  begin errors++; $display("FAIL stall_req got %b expected 0", imem_req); end
      checks++; if (valid_id !== 1'b1)  begin errors++; $display("FAIL stall_valid got %b expected 1", valid_id); end
   endtask

   task automatic test_full_flow();
      int p0;
      logic prev;
      tick();
      id_stall = 1'b0;
      p0 = pop_cnt;
      prev = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL flow_req cycle %0d got %b expected 1", i, imem_req); end
         checks++; if (int'(occupancy) + int'(prev) != DEPTH) begin
            errors++; $display("FAIL flow_credit cycle %0d got %0d expected %0d", i, int'(occupancy) + int'(prev), DEPTH); end
         prev = imem_req;
      end
      #2;
      checks++; if (pop_cnt - p0 != 8) begin errors++; $display("FAIL flow_pops got %0d expected 8", pop_cnt - p0); end
   endtask

   task automatic test_redirect();
      bit found;
      tick();
      id_stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h00400500;
      tick();
      redirect = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (occupancy == 3'd3) begin found = 1'b1; break; end
         tick();
      end
      checks++; if (!found) begin errors++; $display("FAIL redir_fill_timeout got occ=%0d expected 3", occupancy); end
      redirect = 1'b1; redirect_pc = 32'h00400100;
      @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_noreq got %b expected 0", imem_req); end
      tick();
      redirect = 1'b0; id_stall = 1'b0;
      @(negedge clk);
      checks++; if (valid_id !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h00400100) begin
         errors++; $display("FAIL redir_next got valid=%b req=%b addr=%h expected 0 1 00400100", valid_id, imem_req, imem_addr); end
      @(negedge clk);
      checks++; if (valid_id !== 1'b0) begin errors++; $display("FAIL redir_lat2 got %b expected 0", valid_id); end
      @(negedge clk);
      checks++; if (valid_id !== 1'b1 || pc_id !== 32'h00400100) begin
         errors++; $display("FAIL redir_first got valid=%b pc=%h expected 1 00400100", valid_id, pc_id); end
   endtask

   task automatic test_redirect_pop();
      repeat (3) tick();
      @(negedge clk);
      checks++; if (valid_id !== 1'b1) begin errors++; $display("FAIL rpop_head got %b expected 1", valid_id); end
      tick();
      redirect = 1'b1; redirect_pc = 32'h00400103; id_stall = 1'b0;
      @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rpop_noreq got %b expected 0", imem_req); end
      tick();
      redirect = 1'b0;
      @(negedge clk);
      checks++; if (valid_id !== 1'b0 || occupancy !== 3'd0) begin
         errors++; $display("FAIL rpop_flush got valid=%b occ=%0d expected 0 0", valid_id, occupancy); end
      checks++; if (imem_addr !== 32'h00400100) begin errors++; $display("FAIL rpop_align got %h expected 00400100", imem_addr); end
      tick();
      redirect = 1'b1; redirect_pc = 32'h00400200;
      tick();
      redirect_pc = 32'h00400300;
      tick();
      redirect = 1'b0;
      @(negedge clk);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h00400300) begin
         errors++; $display("FAIL b2b_req got req=%b addr=%h expected 1 00400300", imem_req, imem_addr); end
      repeat (2) @(negedge clk);
      checks++; if (valid_id !== 1'b1 || pc_id !== 32'h00400300) begin
         errors++; $display("FAIL b2b_first got valid=%b pc=%h expected 1 00400300", valid_id, pc_id); end
   endtask

   task automatic test_reset_mid();
      bit found;
      tick();
      id_stall = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (occupancy == 3'd2) begin found = 1'b1; break; end
         tick();
      end
      checks++; if (!found) begin errors++; $display("FAIL rmid_fill_timeout got occ=%0d expected 2", occupancy); end
      reset = 1'b1;
      #1;
      checks++; if ({valid_id, instr_id, pc_id, imem_req, occupancy} !== '0) begin
         errors++; $display("FAIL rmid_outputs got valid=%b instr=%h pc=%h req=%b occ=%0d expected all 0",
                            valid_id, instr_id, pc_id, imem_req, occupancy); end
      tick();
      reset = 1'b0; id_stall = 1'b0;
      @(negedge clk);
      checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
         errors++; $display("FAIL rmid_restart got req=%b addr=%h expected 1 %h", imem_req, imem_addr, RST_PC); end
      repeat (2) @(negedge clk);
      checks++; if (valid_id !== 1'b1 || pc_id !== RST_PC) begin
         errors++; $display("FAIL rmid_first got valid=%b pc=%h expected 1 %h", valid_id, pc_id, RST_PC); end
      repeat (5) @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; redirect = 1'b0; redirect_pc = '0; id_stall = 1'b0;
      test_reset();
      test_startup();
      test_stall();
      test_full_flow();
      test_redirect();
      test_redirect_pop();
      test_reset_mid();
      #2;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
